// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the timer arbiter: FSM state encoding,
// default requester count and count width, and a small index helper.
package timer_arb_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Next round-robin position after idx, wrapping at n.
    function automatic int wrapNext(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/timer_arbiter_core.sv
// Countdown register shared by all requesters: loads a duration, then
// decrements toward zero and holds there until reloaded.
module timer_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] r_value;

    // Load has priority; the count saturates at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (dec && (r_value != '0)) begin
            r_value <= r_value - W'(1);
        end
    end

    assign value = r_value;
    assign zero  = (r_value == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one shared countdown timer to N requesters.
// Define TIMER_ARB_CANCEL_EN to add the per-requester cancel input.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_len,
`ifdef TIMER_ARB_CANCEL_EN
    input  logic [N-1:0]         cancel,
`endif
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         expire,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         count
);

    localparam int IW = $clog2(N);

    state_t         r_state;
    state_t         w_stateNext;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  w_ownerNext;
    logic [IW-1:0]  r_rrPtr;
    logic [IW-1:0]  w_rrPtrNext;
    logic [IW-1:0]  w_grantIdx;
    logic           w_anyReq;
    logic           w_load;
    logic           w_dec;
    logic           w_zero;
    logic           w_cancelHit;
    logic [W-1:0]   w_loadValue;
    logic [W-1:0]   w_value;
    logic [N-1:0]   w_grantOH;
    logic [N-1:0]   w_expireOH;

    // First pending request at or after the round-robin pointer, modulo N.
    always_comb begin
        w_anyReq   = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_anyReq && req_valid[(int'(r_rrPtr) + k) % N]) begin
                w_anyReq   = 1'b1;
                w_grantIdx = IW'((int'(r_rrPtr) + k) % N);
            end
        end
    end

`ifdef TIMER_ARB_CANCEL_EN
    assign w_cancelHit = cancel[r_owner];
`else
    assign w_cancelHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rrPtr <= '0;
        end else begin
            r_state <= w_stateNext;
            r_owner <= w_ownerNext;
            r_rrPtr <= w_rrPtrNext;
        end
    end

    // Expiry takes precedence over a cancel arriving on the zero-count cycle.
    always_comb begin
        w_stateNext = r_state;
        w_ownerNext = r_owner;
        w_rrPtrNext = r_rrPtr;
        w_grantOH   = '0;
        w_expireOH  = '0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_loadValue = '0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_grantOH[w_grantIdx] = 1'b1;
                    w_load                = 1'b1;
                    w_loadValue           = req_len[int'(w_grantIdx)*W +: W];
                    w_ownerNext           = w_grantIdx;
                    w_stateNext           = RUN;
                end
            end
            RUN: begin
                if (w_zero) begin
                    w_expireOH[r_owner] = 1'b1;
                    w_rrPtrNext         = IW'(wrapNext(int'(r_owner), N));
                    w_stateNext         = IDLE;
                end else if (w_cancelHit) begin
                    w_rrPtrNext = IW'(wrapNext(int'(r_owner), N));
                    w_stateNext = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    timer_core #(
        .W (W)
    ) u_timerCore (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .dec        (w_dec),
        .load_value (w_loadValue),
        .value      (w_value),
        .zero       (w_zero)
    );

    // Reset overrides everything the same cycle, so all outputs are gated by it.
    assign busy      = !rst && (r_state == RUN);
    assign req_ready = rst ? '0 : w_grantOH;
    assign expire    = rst ? '0 : w_expireOH;
    assign owner     = busy ? r_owner : '0;
    assign count     = busy ? w_value : '0;

    assert property (@(posedge clk) $onehot0(req_ready));
    assert property (@(posedge clk) $onehot0(expire));

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one countdown timer (2..8).
REQ-002 Parameter W, default 8, width of the duration and count values.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N  per-requester level request; held high until accepted.
REQ-006 req_len  input  N*W  per-requester duration; slice i = bits [i*W +: W].
REQ-007 req_ready  output  N  one-hot, one-cycle acceptance pulse.
REQ-008 expire  output  N  one-hot, one-cycle pulse to the owner when its countdown reaches zero.
REQ-009 busy  output  1  high while the timer is owned (state RUN).
REQ-010 owner  output  $clog2(N)  index of the current owner; 0 when idle.
REQ-011 count  output  W  live timer value; 0 when idle.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 IDLE, with no req_valid bit set: hold state; outputs stay at reset values.
REQ-014 IDLE, with any req_valid bit set: grant the first set bit at or after rr_ptr, searching upward modulo N; pulse that req_ready bit; count <= req_len slice; owner <= index; go to RUN, all within the same cycle.
REQ-015 RUN with count != 0: count decrements by 1 per cycle; no other grants are made.
REQ-016 RUN with count == 0: pulse expire[owner]; rr_ptr <= (owner+1) mod N; go to IDLE next cycle.
REQ-017 Latency from the req_ready cycle to the expire cycle SHALL be exactly len+1 cycles; len=0 gives expire on the cycle after acceptance.
REQ-018 No grant SHALL occur in the expire cycle; the earliest re-grant is the following cycle (back-to-back spacing of 1 idle cycle).
REQ-019 Count arithmetic is unsigned W-bit; count never wraps below 0 (it leaves RUN at 0).
REQ-020 Deasserting req_valid of the non-owner while waiting SHALL simply withdraw the request; deasserting the owner's req_valid during RUN has no effect.
REQ-021 req_len is sampled only in the grant cycle; later changes are ignored.
REQ-022 At most one bit of req_ready and at most one bit of expire SHALL be set in any cycle.

Reset
REQ-023 rst SHALL force state IDLE, count 0, owner 0, rr_ptr 0, and req_ready/expire/busy 0, overriding any other event in that cycle.
REQ-024 rst asserted mid-RUN SHALL abort the countdown with no expire pulse.

Configuration
REQ-025 With macro TIMER_ARB_CANCEL_EN defined, an input port cancel (N bits) SHALL exist; cancel[owner]=1 in RUN with count != 0 returns to IDLE next cycle with no expire, count 0, and rr_ptr <= owner+1.
REQ-026 cancel bits of non-owners, or any cancel while IDLE, SHALL be ignored; when cancel[owner] coincides with count == 0, expire wins.
REQ-027 Without TIMER_ARB_CANCEL_EN, the cancel port SHALL be absent and every granted countdown runs to expire.

Structure
REQ-028 Package timer_arb_pkg SHALL hold the state enum (IDLE, RUN) and the default N/W constants.
REQ-029 The countdown SHALL be a sub-module, timer_core (load, dec, value, zero), instantiated once; arbitration and the FSM stay in timer_arbiter.

Verification
REQ-030 Single request: req_valid=0001, len0=3 -> req_ready[0] at T, count 3,2,1,0, expire[0] at T+4, busy low at T+5.
REQ-031 Round robin: all four valid, every len=1 -> grant order 0,1,2,3,0, each expire 2 cycles after its grant, 1 idle cycle between pairs.
REQ-032 Zero length: req 2 with len=0 -> expire[2] one cycle after req_ready[2].
REQ-033 Reset mid-run: owner 1, len=10, rst at count 5 -> no expire; next cycle all outputs 0 and rr_ptr 0.
REQ-034 Cancel (macro on): owner 3, len=6, cancel[3] at count 4 -> IDLE next cycle, no expire[3], next grant goes to 0 if valid; cancel[1] from a non-owner is ignored.
REQ-035 Late len change: req_len0 changed from 5 to 9 one cycle after the grant -> expire still at grant+6.
